// File: rtl/uart_tx_arbiter.sv
// Message-level round-robin arbiter in front of a single uart_tx byte port.
// Bursts from one requester are never interleaved; optional "N:" tag prefix and stall abort.
module uart_tx_arbiter #(
    parameter int          NREQ    = 4,
    parameter bit          TAG_EN  = 1'b1,
    parameter int unsigned TIMEOUT = 65536
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*8-1:0]         req_data,
    input  logic [NREQ-1:0]           req_last,
    output logic [NREQ-1:0]           req_ready,
    output logic                      wreq,
    input  logic                      wgnt,
    output logic [7:0]                wdata,
    output logic [$clog2(NREQ)-1:0]   owner,
    output logic                      busy
);

    localparam int          OW   = $clog2(NREQ);
    localparam logic [31:0] TLIM = 32'(TIMEOUT) - 32'd1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TAG,
        S_SEP,
        S_DATA,
        S_FLUSH
    } state_t;

    state_t          state_reg, state_next;
    logic [OW-1:0]   owner_reg, owner_next;
    logic [OW-1:0]   rr_ptr_reg, rr_ptr_next;
    logic [31:0]     tcnt_reg, tcnt_next;

    logic            grant_found;
    logic [OW-1:0]   grant_idx;
    logic            owner_valid;
    logic            owner_last;
    logic [7:0]      owner_data;

    assign owner_valid = req_valid[owner_reg];
    assign owner_last  = req_last[owner_reg];
    assign owner_data  = req_data[owner_reg*8 +: 8];

    // Scan starts one past the last winner, so the just-served requester comes last.
    always_comb begin
        int scan;
        grant_found = 1'b0;
        grant_idx   = '0;
        scan        = 0;
        for (int k = 1; k <= NREQ; k++) begin
            scan = (int'(rr_ptr_reg) + k) % NREQ;
            if (!grant_found && req_valid[scan]) begin
                grant_found = 1'b1;
                grant_idx   = OW'(scan);
            end
        end
    end

    always_comb begin
        state_next  = state_reg;
        owner_next  = owner_reg;
        rr_ptr_next = rr_ptr_reg;
        tcnt_next   = tcnt_reg;
        wreq        = 1'b0;
        wdata       = 8'h00;
        case (state_reg)
            S_IDLE: begin
                if (grant_found) begin
                    owner_next  = grant_idx;
                    rr_ptr_next = grant_idx;
                    tcnt_next   = '0;
                    state_next  = TAG_EN ? S_TAG : S_DATA;
                end
            end
            S_TAG: begin
                wreq  = 1'b1;
                wdata = 8'h30 + 8'(owner_reg);
                if (wgnt) state_next = S_SEP;
            end
            S_SEP: begin
                wreq  = 1'b1;
                wdata = 8'h3A;
                if (wgnt) begin
                    state_next = S_DATA;
                    tcnt_next  = '0;
                end
            end
            S_DATA: begin
                wreq  = owner_valid;
                wdata = owner_data;
                if (owner_valid && wgnt) begin
                    tcnt_next = '0;
                    if (owner_last) state_next = S_IDLE;
                end else if (!owner_valid) begin
                    // Only an absent owner counts toward the abort; backpressure just holds.
                    tcnt_next = tcnt_reg + 32'd1;
                    if (TIMEOUT != 0 && tcnt_reg == TLIM) state_next = S_FLUSH;
                end
            end
            S_FLUSH: begin
                wreq  = 1'b1;
                wdata = 8'h0A;
                if (wgnt) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
            assign req_ready[gi] = (state_reg == S_DATA) && (owner_reg == OW'(gi)) && wgnt;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= S_IDLE;
            owner_reg  <= '0;
            rr_ptr_reg <= OW'(NREQ - 1);
            tcnt_reg   <= '0;
        end else begin
            state_reg  <= state_next;
            owner_reg  <= owner_next;
            rr_ptr_reg <= rr_ptr_next;
            tcnt_reg   <= tcnt_next;
        end
    end

    assign owner = owner_reg;
    assign busy  = (state_reg != S_IDLE);

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Message-level round-robin arbiter that shares one `uart_tx` byte-write port among `NREQ` independent requesters (debug printers, sector dumpers, status reporters). A message is a burst of bytes terminated by a `last` flag. Once a message starts, it is never interleaved with bytes from another requester. Optionally, each message is prefixed with an ASCII channel tag. A stalled message is aborted after a timeout. The block sits directly in front of `uart_tx` (`BYTE_WIDTH=1`) and drives its `wreq`/`wdata`, consuming `wgnt`.

## Interface
- `NREQ`, 4: number of requesters, legal range 2..8.
- `TAG_EN`, 1: 1 = emit tag byte `"0"+owner` then `":"` (0x3A) before each message; 0 = no prefix.
- `TIMEOUT`, 65536: idle-cycle limit for the owner mid-message; 0 disables the abort.

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  NREQ  requester i presents a byte.
- `req_data`  in  NREQ*8  byte of requester i at `[i*8 +: 8]`.
- `req_last`  in  NREQ  byte of requester i is the last byte of its message.
- `req_ready`  out  NREQ  byte of requester i accepted this cycle (combinational).
- `wreq`  out  1  to `uart_tx` `wreq`.
- `wgnt`  in  1  from `uart_tx`; combinational `fifo_full_n & wreq`.
- `wdata`  out  8  to `uart_tx` `wdata`.
- `owner`  out  $clog2(NREQ)  current or last granted requester.
- `busy`  out  1  state is not IDLE.

## Operation
- **Downstream transfer:** `wreq & wgnt` in the same cycle. **Upstream transfer i:** `req_valid[i] & req_ready[i]`.
- **States:** IDLE, TAG, SEP, DATA, FLUSH.
- **IDLE**
  - `wreq=0`, `wdata=0`, `req_ready=0`.
  - If any `req_valid` bit is set, select the first i scanning `rr_ptr+1, rr_ptr+2, …` modulo NREQ.
  - Register `owner=i` and `rr_ptr=i`.
  - Go to TAG if `TAG_EN=1`, otherwise DATA.
- **TAG**
  - `wreq=1`, `wdata="0"+owner`.
  - On `wgnt`, go to SEP.
- **SEP**
  - `wreq=1`, `wdata=8'h3A`.
  - On `wgnt`, go to DATA.
- **DATA** (combinational pass-through)
  - `wreq=req_valid[owner]`, `wdata=req_data[owner]`, `req_ready[owner]=wgnt`; all other `req_ready` bits are 0.
  - On a transfer with `req_last[owner]=1`, go to IDLE.
- **Timeout** (DATA only)
  - Counter `tcnt` (32 bit) is cleared on entering DATA and on every upstream transfer.
  - `tcnt` increments in each DATA cycle with `req_valid[owner]=0`.
  - `tcnt` holds when `req_valid[owner]=1` but `wgnt=0`; downstream backpressure never aborts.
  - When `TIMEOUT!=0` and `tcnt==TIMEOUT-1` in an incrementing cycle, go to FLUSH.
- **FLUSH**
  - `wreq=1`, `wdata=8'h0A`.
  - On `wgnt`, go to IDLE.
  - The aborted requester stays unserved until it is regranted. Its later bytes start a new message.
- `req_last` is ignored in TAG, SEP and FLUSH.
- A requester may drop `req_valid` mid-message; this only advances the timeout.
- Requests from non-owners are held off without loss; their `req_ready` stays 0.

## Timing
- **Reset values** (applied on the clock edge with `rst=1`): state IDLE, `wreq=0`, `wdata=0`, `req_ready=0`, `busy=0`, `owner=0`, `rr_ptr=NREQ-1` (requester 0 wins first), `tcnt=0`.
- **Reset mid-message:** the message is truncated with no FLUSH byte, and state returns to IDLE next cycle.
- **Grant latency:** `req_valid` seen in IDLE at cycle t gives `wreq=1` at t+1, showing the tag (`TAG_EN=1`) or the first data byte (`TAG_EN=0`).
- **Message gap:** the `last` transfer at cycle t puts the block in IDLE at t+1 and grants the next owner at t+2.
  - A gap of exactly 1 idle cycle between back-to-back messages is required.
- **Simultaneous requests:** exactly one requester is granted per arbitration.
  - The just-served requester has lowest priority at the next arbitration.
  - A continuously requesting set is served in strict rotation.
- **Wrap-around:** the scan from `rr_ptr=NREQ-1` wraps to 0.
- **Full FIFO** (`wgnt=0` while `wreq=1`): all outputs hold and the state does not advance.
- `wdata` is 0 whenever `wreq=0`, except in DATA, where it mirrors `req_data[owner]`.

## Test plan
- **Reset then single message:** reset, then requester 2 sends "AB" (`last` on 'B') with `TAG_EN=1`, `wgnt` tied to `wreq` → `wdata` sequence 0x32, 0x3A, 0x41, 0x42, then IDLE. The first `wreq` comes 1 cycle after IDLE sees valid.
- **Round-robin:** all 4 requesters send continuous 1-byte messages → owner order 0,1,2,3,0,… with exactly 1 idle cycle between messages and no interleaving.
- **Backpressure:** hold `wgnt=0` for 50 cycles mid-DATA with owner valid, `TIMEOUT=16` → no abort, stream resumes intact.
- **Timeout:** with `TIMEOUT=16`, the owner drops valid mid-message → after 16 idle cycles, FLUSH emits 0x0A, then the next requester is granted.
- **Mid-message reset:** assert `rst` for 1 cycle during DATA → next cycle all outputs are 0 and `busy=0`. The next grant goes to requester 0 if it is requesting.
- **Tag disabled:** `TAG_EN=0`, requester 1 sends "x" → single byte 0x78 on `wdata`, with `req_ready[1]` high in the same cycle as `wgnt`.
